btn_conditioner: RTL and testbench



---
 rtl/btn_conditioner.sv | 164 ++++++++++++++++
 tb/tb_btn_conditioner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions raw push-buttons into clean clk-synchronous control.
// Each channel has a 2-FF synchronizer, a counter debounce with press/release
// pulses, and optional auto-repeat pulses while the button is held.
//
// Ports:
//   clk          system clock
//   rst_n        synchronous active-low reset
//   btn_in       [N_BTN] raw asynchronous buttons, active-high
//   repeat_en    [N_BTN] per-channel auto-repeat enable
//   btn_level    [N_BTN] debounced level
//   btn_press    [N_BTN] one-cycle pulse on accepted press
//   btn_release  [N_BTN] one-cycle pulse on accepted release
//   btn_repeat   [N_BTN] one-cycle auto-repeat pulse

module btn_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 10,
    parameter int REPEAT_CYCLES   = 3,
    parameter int CW              = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    typedef enum logic [2:0] {IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE} state_t;

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync1, s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            sync1       <= 1'b0;
            s           <= 1'b0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
        end else begin
            sync1       <= btn_in;
            s           <= sync1;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_repeat  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (s) state <= DB_PRESS;
                end
                DB_PRESS: begin
                    if (!s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (!repeat_en) begin
                        cnt <= '0;
                    end else if (cnt == HOLD_LAST) begin
                        state      <= REPEAT;
                        cnt        <= '0;
                        btn_repeat <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                REPEAT: begin
                    if (!s) begin
                        state <= DB_RELEASE;
                        cnt   <= '0;
                    end else if (!repeat_en) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == REP_LAST) begin
                        cnt        <= '0;
                        btn_repeat <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DB_RELEASE: begin
                    // A bounce back to 1 restarts the hold timer from HELD.
                    if (s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 20000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int MAX_DH = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_C  = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    btn_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CW              (CW)
    ) u_chan [N_BTN-1:0] (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: run-length reference model checked every cycle,
// directed scenarios with hand-computed pulse times, then randomized stimulus.

module tb_btn_conditioner;

    localparam int NB = 2;
    localparam int DB = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] btn_in = '0;
    logic [NB-1:0] repeat_en = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

    always #5 clk = ~clk;

    btn_conditioner #(
        .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .REPEAT_CYCLES(RC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_repeat(btn_repeat)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: synchronized input is btn_in two edges late; a press is
    // accepted after DB+1 consecutive 1 samples at level 0, a release after DB+1
    // consecutive 0 samples at level 1. Repeats fire when the uninterrupted
    // count of held samples with repeat enabled hits HC, then every RC more.
    logic [NB-1:0] m_s1 = '0, m_s = '0;
    logic [NB-1:0] e_level = '0, e_press = '0, e_rel = '0, e_rep = '0;
    int one_run[NB], zero_run[NB], qrun[NB];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 = '0; m_s = '0;
            e_level = '0; e_press = '0; e_rel = '0; e_rep = '0;
            for (int c = 0; c < NB; c++) begin
                one_run[c] = 0; zero_run[c] = 0; qrun[c] = 0;
            end
        end else begin
            e_press = '0; e_rel = '0; e_rep = '0;
            for (int c = 0; c < NB; c++) begin
                if (!e_level[c]) begin
                    one_run[c] = m_s[c] ? one_run[c] + 1 : 0;
                    if (one_run[c] == DB + 1) begin
                        e_level[c] = 1'b1; e_press[c] = 1'b1;
                        one_run[c] = 0; zero_run[c] = 0; qrun[c] = 0;
                    end
                end else if (!m_s[c]) begin
                    zero_run[c]++;
                    qrun[c] = 0;
                    if (zero_run[c] == DB + 1) begin
                        e_level[c] = 1'b0; e_rel[c] = 1'b1;
                        zero_run[c] = 0; one_run[c] = 0;
                    end
                end else if (zero_run[c] > 0) begin
                    zero_run[c] = 0;
                    qrun[c] = 0;
                end else if (repeat_en[c]) begin
                    qrun[c]++;
                    if (qrun[c] >= HC && (qrun[c] - HC) % RC == 0) e_rep[c] = 1'b1;
                end else begin
                    qrun[c] = 0;
                end
            end
            m_s  = m_s1;
            m_s1 = btn_in;
        end
    end

    bit chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            total++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !==
                {e_level, e_press, e_rel, e_rep}) begin
                bad++;
                $display("FAIL model t=%0t got lvl=%b prs=%b rel=%b rep=%b want lvl=%b prs=%b rel=%b rep=%b",
                         $time, btn_level, btn_press, btn_release, btn_repeat,
                         e_level, e_press, e_rel, e_rep);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Pulse recorder: n is the index of the edge just passed (first edge = 0).
    int n;
    int p_at[NB], r_at[NB];
    int rep_cnt, rep_first, rep_last;

    task automatic clear_rec();
        n = -1;
        for (int c = 0; c < NB; c++) begin p_at[c] = -1; r_at[c] = -1; end
        rep_cnt = 0; rep_first = -1; rep_last = -1;
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
        for (int c = 0; c < NB; c++) begin
            if (btn_press[c] && p_at[c] < 0) p_at[c] = n;
            if (btn_release[c] && r_at[c] < 0) r_at[c] = n;
        end
        if (btn_repeat[0]) begin
            rep_cnt++;
            if (rep_first < 0) rep_first = n;
            rep_last = n;
        end
    endtask

    initial begin
        logic [4:0] pat;
        int run_left[NB];
        clear_rec();
        rst_n = 1'b0;
        tick();
        chk_on = 1'b1;
        tick(); tick();
        check("reset_outputs", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        rst_n = 1'b1;
        tick(); tick();

        // Clean press and clean release on channel 0.
        clear_rec();
        btn_in[0] = 1'b1;
        repeat (10) tick();
        check("clean_press_at", p_at[0], 6);
        check("clean_level0", int'(btn_level[0]), 1);
        check("clean_no_press1", p_at[1], -1);
        check("clean_level1", int'(btn_level[1]), 0);
        clear_rec();
        btn_in[0] = 1'b0;
        repeat (10) tick();
        check("clean_release_at", r_at[0], 6);

        // Press bounce 1,0,1,1,0 then held.
        clear_rec();
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            btn_in[0] = pat[i];
            tick();
        end
        btn_in[0] = 1'b1;
        repeat (12) tick();
        check("bounce_press_at", p_at[0], 11);

        // Release with a one-cycle glitch back to 1.
        clear_rec();
        btn_in[0] = 1'b0; tick(); tick();
        btn_in[0] = 1'b1; tick();
        btn_in[0] = 1'b0;
        repeat (12) tick();
        check("bounce_release_at", r_at[0], 9);
        check("bounce_release_no_press", p_at[0], -1);
        check("bounce_release_level", int'(btn_level[0]), 0);

        // Auto-repeat, enable dropped so edge 20 samples it low.
        clear_rec();
        repeat_en[0] = 1'b1;
        btn_in[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (n == 19) repeat_en[0] = 1'b0;
        end
        check("repeat_press_at", p_at[0], 6);
        check("repeat_first", rep_first, 16);
        check("repeat_last", rep_last, 19);
        check("repeat_count", rep_cnt, 2);

        // Reset while held, then re-debounce after release of reset.
        rst_n = 1'b0;
        tick();
        check("midreset_outputs", int'({btn_level, btn_press, btn_release, btn_repeat}), 0);
        tick(); tick();
        clear_rec();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_reset_press_at", p_at[0], 6);

        // Independence: channel 1 pressed two cycles after channel 0.
        btn_in = '0;
        repeat (12) tick();
        clear_rec();
        btn_in[0] = 1'b1; tick(); tick();
        btn_in[1] = 1'b1;
        repeat (12) tick();
        check("indep_press0_at", p_at[0], 6);
        check("indep_press1_at", p_at[1], 8);
        btn_in = '0;
        repeat (12) tick();

        // Randomized: mixes bounces, long holds, enable toggles and resets.
        for (int c = 0; c < NB; c++) run_left[c] = 0;
        for (int k = 0; k < 4000; k++) begin
            for (int c = 0; c < NB; c++) begin
                if (run_left[c] == 0) begin
                    btn_in[c] = ~btn_in[c];
                    run_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                              : $urandom_range(5, 40);
                end else begin
                    run_left[c]--;
                end
            end
            if ($urandom_range(0, 49) == 0) repeat_en = NB'($urandom);
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
